// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback-stage register file with late-load wait, bypassed read ports and commit counter
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] WB_result,
  input  logic [ADDR_W-1:0] WB_rd_addr,
  input  logic              WB_rmem,
  input  logic              WB_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              wb_stall,
  output logic [CNT_W-1:0]  wb_retire_cnt
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  regs_q [2**ADDR_W];

  logic               commit;
  logic [ADDR_W-1:0]  waddr;
  logic [DATA_W-1:0]  wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    case (state_q)
      IDLE: begin
        if (WB_wen && WB_rmem && !mem_rvalid) begin
          state_d   = WAIT_LOAD;
          pend_rd_d = WB_rd_addr;
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit selection; reset suppresses both writes and stall.
  always_comb begin
    commit   = 1'b0;
    waddr    = WB_rd_addr;
    wdata    = WB_rmem ? mem_rdata : WB_result;
    wb_stall = 1'b0;
    case (state_q)
      IDLE: begin
        commit   = WB_wen && (!WB_rmem || mem_rvalid);
        wb_stall = WB_wen && WB_rmem && !mem_rvalid;
      end
      WAIT_LOAD: begin
        commit   = mem_rvalid;
        waddr    = pend_rd_q;
        wdata    = mem_rdata;
        wb_stall = !mem_rvalid;
      end
      default: begin
        commit   = 1'b0;
        wb_stall = 1'b0;
      end
    endcase
    if (rst) begin
      commit   = 1'b0;
      wb_stall = 1'b0;
    end
  end

  assign cnt_d         = commit ? cnt_q + CNT_W'(1) : cnt_q;
  assign wb_retire_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs_q[i] <= '0;
    end else if (commit && waddr != '0) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    if (rs1_addr == '0)                   rs1_data = '0;
    else if (commit && waddr == rs1_addr) rs1_data = wdata;
    else                                  rs1_data = regs_q[rs1_addr];
  end

  always_comb begin
    if (rs2_addr == '0)                   rs2_data = '0;
    else if (commit && waddr == rs2_addr) rs2_data = wdata;
    else                                  rs2_data = regs_q[rs2_addr];
  end

endmodule
